// File: rtl/uart_msg_echo_ctrl.sv
// rtl/uart_msg_echo_ctrl.sv - periodic message sender with buffered RX echo between uart_rx and uart_tx
//
// Sends MSG (MSG_LEN bytes, first byte in the MSBs) to uart_tx. After the last byte is
// accepted, the block waits PERIOD_CYC = CLK_FRE*1000*PERIOD_MS cycles before the next message starts.
// Every byte received from uart_rx goes into a 2**FIFO_AW deep FIFO. The block accepts
// RX bytes in every state. Bytes are echoed in arrival order while the block waits between messages.
//
// Optional feature macro: UART_ECHO_UPPER_EN
//   defined   - echoed bytes 'a'..'z' are converted to 'A'..'Z' when they are popped
//   undefined - echoed bytes are sent unmodified
//
// Ports
//   clk            in   1   system clock, all logic on posedge
//   rst_n          in   1   synchronous active-low reset
//   rx_data        in   8   byte from uart_rx
//   rx_data_valid  in   1   rx_data valid
//   rx_data_ready  out  1   FIFO can take a byte (combinational, low during reset)
//   tx_data        out  8   byte to uart_tx (registered)
//   tx_data_valid  out  1   tx_data valid (registered)
//   tx_data_ready  in   1   uart_tx accepts tx_data
//   msg_cnt        out  16  messages fully sent, wrapping
//   rx_ovf         out  1   sticky: rx_data_valid seen while FIFO full

module uart_msg_echo_ctrl #(
    parameter int                   CLK_FRE   = 50,
    parameter int                   PERIOD_MS = 1000,
    parameter int                   MSG_LEN   = 13,
    parameter logic [8*MSG_LEN-1:0] MSG       = "HELLO ALINX\r\n",
    parameter int                   FIFO_AW   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic        rx_data_ready,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic [15:0] msg_cnt,
    output logic        rx_ovf
);

    localparam int               DEPTH      = 2**FIFO_AW;
    localparam logic [31:0]      PERIOD_CYC = 32'(CLK_FRE * 1000 * PERIOD_MS);
    localparam logic [31:0]      TIMER_MAX  = PERIOD_CYC - 32'd1;
    localparam logic [7:0]       LAST_IDX   = 8'(MSG_LEN - 1);
    localparam logic [FIFO_AW:0] FULL_CNT   = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t             state, state_nxt;
    logic [7:0]         idx, idx_nxt;
    logic [31:0]        timer, timer_nxt;
    logic [7:0]         tx_data_nxt;
    logic               tx_valid_nxt;
    logic [15:0]        msg_cnt_nxt;

    logic [7:0]         mem [0:DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               tx_accept;

    // Byte i of the message; byte 0 is held in the most significant byte of MSG.
    function automatic logic [7:0] msg_byte(input logic [7:0] i);
        logic [8*MSG_LEN-1:0] sh;
        sh = MSG >> (8 * (MSG_LEN - 1 - int'(i)));
        return sh[7:0];
    endfunction

    // Transformation applied to echoed bytes as they leave the FIFO.
    function automatic logic [7:0] echo_map(input logic [7:0] b);
`ifdef UART_ECHO_UPPER_EN
        if (b >= 8'h61 && b <= 8'h7A) begin
            return b - 8'h20;
        end
        return b;
`else
        return b;
`endif
    endfunction

    assign fifo_full     = (fifo_cnt == FULL_CNT);
    assign fifo_empty    = (fifo_cnt == '0);
    assign rx_data_ready = !fifo_full && rst_n;
    assign push          = rx_data_valid && rx_data_ready;
    assign tx_accept     = tx_data_valid && tx_data_ready;

    // Next-state and output logic
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        timer_nxt    = timer;
        tx_data_nxt  = tx_data;
        tx_valid_nxt = tx_data_valid;
        msg_cnt_nxt  = msg_cnt;
        pop          = 1'b0;

        case (state)
            ST_IDLE: begin
                state_nxt    = ST_SEND;
                idx_nxt      = 8'd0;
                tx_data_nxt  = msg_byte(8'd0);
                tx_valid_nxt = 1'b1;
            end

            ST_SEND: begin
                if (tx_accept) begin
                    if (idx < LAST_IDX) begin
                        // Load the next byte on the accepting edge so bytes run back-to-back.
                        idx_nxt     = idx + 8'd1;
                        tx_data_nxt = msg_byte(idx + 8'd1);
                    end else begin
                        tx_valid_nxt = 1'b0;
                        idx_nxt      = 8'd0;
                        msg_cnt_nxt  = msg_cnt + 16'd1;
                        timer_nxt    = 32'd0;
                        state_nxt    = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (timer != TIMER_MAX) begin
                    timer_nxt = timer + 32'd1;
                end
                // An echo in flight always completes first. After it is accepted, the
                // cycle with valid low separates echo pops and delays a pending message start.
                if (tx_data_valid) begin
                    if (tx_data_ready) begin
                        tx_valid_nxt = 1'b0;
                    end
                end else if (timer == TIMER_MAX) begin
                    state_nxt    = ST_SEND;
                    idx_nxt      = 8'd0;
                    tx_data_nxt  = msg_byte(8'd0);
                    tx_valid_nxt = 1'b1;
                end else if (!fifo_empty) begin
                    pop          = 1'b1;
                    tx_data_nxt  = echo_map(mem[rd_ptr]);
                    tx_valid_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            idx           <= 8'd0;
            timer         <= 32'd0;
            tx_data       <= 8'd0;
            tx_data_valid <= 1'b0;
            msg_cnt       <= 16'd0;
            rx_ovf        <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            timer         <= timer_nxt;
            tx_data       <= tx_data_nxt;
            tx_data_valid <= tx_valid_nxt;
            msg_cnt       <= msg_cnt_nxt;
            if (rx_data_valid && fifo_full) begin
                rx_ovf <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_AW bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage needs no reset; push is already gated by rst_n via rx_data_ready.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

endmodule
